// File: rtl/tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tx_arbiter_pkg
//   Shared bridge definitions: default AXI-Stream widths, the Tx arbiter
//   state encoding, the source-select encoding used for the last_grant
//   pointer, and the helper that decodes the one-hot grant from the state.
//   Imported by tx_arbiter and by axis_reg_slice.
// ---------------------------------------------------------------------------
package tx_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 64;
  localparam int unsigned KEEP_WIDTH_DEFAULT = DATA_WIDTH_DEFAULT / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_sel_t;

  // One-hot owner: 01 = source 0, 10 = source 1, 00 = nobody.
  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      GRANT0:  return 2'b01;
      GRANT1:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/tx_arbiter_reg_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice
//   Two-entry AXI-Stream register slice (skid buffer). Every m_* output is a
//   flop, and s_ready depends only on internal state, so the slice breaks all
//   combinational paths in both directions while still sustaining one beat
//   per cycle.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   s_data/keep/last/valid, s_ready   upstream beat and its acceptance
//   m_data/keep/last/valid, m_ready   downstream beat and its acceptance
//   empty           high when no beat is held
// ---------------------------------------------------------------------------
module axis_reg_slice
  import tx_arbiter_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH_DEFAULT,
  parameter int unsigned keep_width = KEEP_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] s_data,
  input  logic [keep_width-1:0] s_keep,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [data_width-1:0] m_data,
  output logic [keep_width-1:0] m_keep,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  empty
);

  logic                  out_valid;
  logic [data_width-1:0] out_data;
  logic [keep_width-1:0] out_keep;
  logic                  out_last;

  logic                  skid_valid;
  logic [data_width-1:0] skid_data;
  logic [keep_width-1:0] skid_keep;
  logic                  skid_last;

  logic                  push;
  logic                  pop;

  // The skid entry only fills while the output entry is stalled, so
  // "skid occupied" is the same as "both entries occupied".
  assign s_ready = !skid_valid;
  assign push    = s_valid && s_ready;
  assign pop     = out_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_last  <= 1'b0;
    end else if (!out_valid || pop) begin
      // Output entry is free this cycle: refill from skid first (older beat),
      // otherwise straight from the input.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_keep   <= skid_keep;
        out_last   <= skid_last;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) begin
          out_data <= s_data;
          out_keep <= s_keep;
          out_last <= s_last;
        end
      end
    end else if (push) begin
      // Output stalled: park the incoming beat in the skid entry.
      skid_valid <= 1'b1;
      skid_data  <= s_data;
      skid_keep  <= s_keep;
      skid_last  <= s_last;
    end
  end

  assign m_valid = out_valid;
  assign m_data  = out_data;
  assign m_keep  = out_keep;
  assign m_last  = out_last;
  assign empty   = !out_valid;

endmodule

// File: rtl/tx_arbiter.sv
// ---------------------------------------------------------------------------
// tx_arbiter
//   Packet-locked round-robin arbiter merging the completion-engine stream
//   (source 0) and the message/error-engine stream (source 1) onto the PCIe
//   core AXI Tx stream through a two-entry register slice.
//
// Ports
//   rx_clk, rx_reset                 bridge clock, async active-high reset
//   src0_data/keep/last/valid/ready  source 0 stream
//   src1_data/keep/last/valid/ready  source 1 stream
//   tx_data/keep/last/valid/ready    PCIe core Tx stream (registered outputs)
//   grant                            one-hot current owner
//   busy                             packet in flight or slice occupied
// ---------------------------------------------------------------------------
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH_DEFAULT,
  parameter int unsigned keep_width = KEEP_WIDTH_DEFAULT
) (
  input  logic                  rx_clk,
  input  logic                  rx_reset,
  input  logic [data_width-1:0] src0_data,
  input  logic [keep_width-1:0] src0_keep,
  input  logic                  src0_valid,
  input  logic                  src0_last,
  output logic                  src0_ready,
  input  logic [data_width-1:0] src1_data,
  input  logic [keep_width-1:0] src1_keep,
  input  logic                  src1_valid,
  input  logic                  src1_last,
  output logic                  src1_ready,
  output logic [data_width-1:0] tx_data,
  output logic [keep_width-1:0] tx_keep,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic [1:0]            grant,
  output logic                  busy
);

  arb_state_t state;
  arb_state_t state_next;
  src_sel_t   last_grant;

  logic                  slice_ready;
  logic                  slice_empty;
  logic                  mux_valid;
  logic [data_width-1:0] mux_data;
  logic [keep_width-1:0] mux_keep;
  logic                  mux_last;

  always_ff @(posedge rx_clk or posedge rx_reset) begin
    if (rx_reset) begin
      state      <= IDLE;
      last_grant <= SRC1;   // source 0 wins the first tie after reset
    end else begin
      state <= state_next;
      if (state_next == GRANT0) begin
        last_grant <= SRC0;
      end else if (state_next == GRANT1) begin
        last_grant <= SRC1;
      end
    end
  end

  // Next state plus source-side handshake and data mux. Readies depend only
  // on the state register and the slice occupancy, never on src*_valid.
  always_comb begin
    state_next = state;
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    mux_valid  = 1'b0;
    mux_data   = src0_data;
    mux_keep   = src0_keep;
    mux_last   = src0_last;

    unique case (state)
      IDLE: begin
        if (src0_valid && src1_valid) begin
          state_next = (last_grant == SRC1) ? GRANT0 : GRANT1;
        end else if (src0_valid) begin
          state_next = GRANT0;
        end else if (src1_valid) begin
          state_next = GRANT1;
        end
      end

      GRANT0: begin
        src0_ready = slice_ready;
        mux_valid  = src0_valid;
        // Hand over directly to a waiting source 1 to avoid an idle bubble.
        if (src0_valid && slice_ready && src0_last) begin
          state_next = src1_valid ? GRANT1 : IDLE;
        end
      end

      GRANT1: begin
        src1_ready = slice_ready;
        mux_valid  = src1_valid;
        mux_data   = src1_data;
        mux_keep   = src1_keep;
        mux_last   = src1_last;
        if (src1_valid && slice_ready && src1_last) begin
          state_next = src0_valid ? GRANT0 : IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  axis_reg_slice #(
    .data_width(data_width),
    .keep_width(keep_width)
  ) u_slice (
    .clk     (rx_clk),
    .rst     (rx_reset),
    .s_data  (mux_data),
    .s_keep  (mux_keep),
    .s_last  (mux_last),
    .s_valid (mux_valid),
    .s_ready (slice_ready),
    .m_data  (tx_data),
    .m_keep  (tx_keep),
    .m_last  (tx_last),
    .m_valid (tx_valid),
    .m_ready (tx_ready),
    .empty   (slice_empty)
  );

  assign grant = grant_of(state);
  assign busy  = (state != IDLE) || !slice_empty;

endmodule

// File: tb/tb_tx_arbiter.sv
module tb_tx_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } txrec_t;

  typedef struct {
    int src;
    int cyc;
  } srcrec_t;

  logic          rx_clk;
  logic          rx_reset;
  logic [DW-1:0] src0_data, src1_data, tx_data;
  logic [KW-1:0] src0_keep, src1_keep, tx_keep;
  logic          src0_valid, src1_valid, src0_last, src1_last;
  logic          src0_ready, src1_ready;
  logic          tx_valid, tx_last, tx_ready;
  logic [1:0]    grant;
  logic          busy;

  logic [DW-1:0] sd [2];
  logic [KW-1:0] sk [2];
  logic          sv [2];
  logic          sl [2];

  assign src0_data  = sd[0];
  assign src0_keep  = sk[0];
  assign src0_valid = sv[0];
  assign src0_last  = sl[0];
  assign src1_data  = sd[1];
  assign src1_keep  = sk[1];
  assign src1_valid = sv[1];
  assign src1_last  = sl[1];

  tx_arbiter #(
    .data_width(DW),
    .keep_width(KW)
  ) dut (
    .rx_clk     (rx_clk),
    .rx_reset   (rx_reset),
    .src0_data  (src0_data),
    .src0_keep  (src0_keep),
    .src0_valid (src0_valid),
    .src0_last  (src0_last),
    .src0_ready (src0_ready),
    .src1_data  (src1_data),
    .src1_keep  (src1_keep),
    .src1_valid (src1_valid),
    .src1_last  (src1_last),
    .src1_ready (src1_ready),
    .tx_data    (tx_data),
    .tx_keep    (tx_keep),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .grant      (grant),
    .busy       (busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  beat_t   pq0[$];
  beat_t   pq1[$];
  beat_t   exp_q[$];
  txrec_t  txlog[$];
  srcrec_t srclog[$];

  beat_t cur [2];
  bit    have [2];
  bit    fired [2];
  int    owner = -1;
  int    must_next = -1;
  int    tr_mode = 0;     // 0: ready high, 1: ready low, 2: random
  int    rand_beats = 0;

  bit            stall = 0;
  logic [DW-1:0] hold_data;
  logic [KW-1:0] hold_keep;
  logic          hold_last;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name, input int waited);
    checks++;
    failures++;
    $display("FAIL %s: timed out after %0d cycles, required completion", name, waited);
  endtask

  // clock and cycle counter
  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  initial forever begin
    @(posedge rx_clk);
    cyc++;
  end

  // tx_ready driver
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge rx_clk);
      #1;
      case (tr_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'b0;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // source drivers: never withdraw a presented beat
  task automatic drive_src(input int n);
    forever begin
      @(posedge rx_clk);
      #1;
      if (rx_reset) begin
        have[n] = 1'b0;
        sv[n]   = 1'b0;
      end else begin
        if (have[n] && sv[n] && fired[n]) begin
          have[n] = 1'b0;
          sv[n]   = 1'b0;
        end
        if (!have[n]) begin
          if (n == 0 && pq0.size() > 0) begin
            cur[n] = pq0.pop_front();
            have[n] = 1'b1;
          end else if (n == 1 && pq1.size() > 0) begin
            cur[n] = pq1.pop_front();
            have[n] = 1'b1;
          end
        end
        if (have[n] && cur[n].gap > 0) begin
          cur[n].gap = cur[n].gap - 1;
          sv[n] = 1'b0;
        end else if (have[n]) begin
          sd[n] = cur[n].data;
          sk[n] = cur[n].keep;
          sl[n] = cur[n].last;
          sv[n] = 1'b1;
        end else begin
          sv[n] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    sd[0] = '0; sk[0] = '0; sl[0] = 1'b0; sv[0] = 1'b0; have[0] = 1'b0;
    drive_src(0);
  end

  initial begin
    sd[1] = '0; sk[1] = '0; sl[1] = 1'b0; sv[1] = 1'b0; have[1] = 1'b0;
    drive_src(1);
  end

  // Reference rules at packet level: accepted beats leave in order; an owner
  // keeps the link until its last beat; a source waiting when the owner's
  // last beat goes is served next.
  task automatic accept(input int n, input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic l, input logic other_valid);
    beat_t b;
    if (owner >= 0) begin
      check_int("no_interleave_src", n, owner);
    end else begin
      if (must_next >= 0) check_int("handover_src", n, must_next);
      must_next = -1;
    end
    b.data = d;
    b.keep = k;
    b.last = l;
    b.gap  = 0;
    exp_q.push_back(b);
    srclog.push_back('{n, cyc});
    if (l) begin
      owner = -1;
      must_next = other_valid ? 1 - n : -1;
    end else begin
      owner = n;
    end
  endtask

  // monitor / scoreboard
  initial begin
    beat_t e;
    fired[0] = 1'b0;
    fired[1] = 1'b0;
    forever begin
      @(negedge rx_clk);
      if (rx_reset) begin
        fired[0] = 1'b0;
        fired[1] = 1'b0;
        stall = 1'b0;
        exp_q.delete();
        owner = -1;
        must_next = -1;
      end else begin
        check_vec("ready_exclusive", 128'(src0_ready & src1_ready), 128'(0));
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected: actual beat %0h required none", tx_data);
          end else begin
            e = exp_q.pop_front();
            check_vec("tx_beat", 128'({tx_data, tx_keep, tx_last}), 128'({e.data, e.keep, e.last}));
          end
          txlog.push_back('{tx_data, tx_last, cyc});
        end
        if (stall)
          check_vec("tx_hold_stable", 128'({tx_valid, tx_data, tx_keep, tx_last}),
                    128'({1'b1, hold_data, hold_keep, hold_last}));
        stall     = tx_valid && !tx_ready;
        hold_data = tx_data;
        hold_keep = tx_keep;
        hold_last = tx_last;
        fired[0] = src0_valid && src0_ready;
        fired[1] = src1_valid && src1_ready;
        if (fired[0]) accept(0, src0_data, src0_keep, src0_last, src1_valid);
        if (fired[1]) accept(1, src1_data, src1_keep, src1_last, src0_valid);
        check_int("slice_occupancy_max2", (exp_q.size() <= 2) ? 1 : 0, 1);
      end
    end
  end

  task automatic push_beat(input int n, input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input int g);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    b.gap  = g;
    if (n == 0) pq0.push_back(b);
    else        pq1.push_back(b);
  endtask

  task automatic push_pkt(input int n, input logic [DW-1:0] base, input int len);
    for (int i = 0; i < len; i++)
      push_beat(n, base + DW'(i), (i == len - 1) ? 8'h3F : 8'hFF, i == len - 1, 0);
  endtask

  task automatic push_rand_pkt(input int n);
    int len;
    len = $urandom_range(1, 6);
    for (int i = 0; i < len; i++) begin
      push_beat(n, {$urandom, $urandom}, KW'($urandom_range(1, 255)), i == len - 1,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      rand_beats++;
    end
  endtask

  task automatic clear_logs();
    txlog.delete();
    srclog.delete();
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge rx_clk);
      if (pq0.size() == 0 && pq1.size() == 0 && !have[0] && !have[1] &&
          !busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout(name, limit);
  endtask

  task automatic wait_grant(input string name, input logic [1:0] g);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge rx_clk);
      if (grant == g) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout(name, 50);
  endtask

  task automatic check_tx(input string name, input logic [DW-1:0] ev[$]);
    check_int({name, "_count"}, txlog.size(), ev.size());
    foreach (ev[i])
      if (i < txlog.size()) check_vec({name, "_data"}, 128'(txlog[i].data), 128'(ev[i]));
  endtask

  task automatic do_reset();
    @(posedge rx_clk);
    #3;
    rx_reset = 1'b1;
    pq0.delete();
    pq1.delete();
    repeat (2) @(negedge rx_clk);
    @(posedge rx_clk);
    #3;
    rx_reset = 1'b0;
    @(negedge rx_clk);
  endtask

  // watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] ev[$];
    bit ok;
    rx_reset = 1'b1;
    repeat (3) @(posedge rx_clk);
    @(negedge rx_clk);
    check_vec("reset_outputs",
              128'({tx_valid, tx_last, tx_data, tx_keep, src0_ready, src1_ready, grant, busy}), 128'(0));
    @(posedge rx_clk);
    #3;
    rx_reset = 1'b0;
    @(negedge rx_clk);
    check_vec("post_reset_outputs",
              128'({tx_valid, tx_last, tx_data, tx_keep, src0_ready, src1_ready, grant, busy}), 128'(0));

    // single 3-beat packet from source 0
    clear_logs();
    push_beat(0, 64'h11, 8'hFF, 1'b0, 0);
    push_beat(0, 64'h22, 8'hFF, 1'b0, 0);
    push_beat(0, 64'h33, 8'h0F, 1'b1, 0);
    @(negedge rx_clk);
    check_vec("t1_idle_arbitrate", 128'({src0_valid, src0_ready, src1_ready, grant}), 128'(5'b10000));
    @(negedge rx_clk);
    check_vec("t1_grant01", 128'({src0_ready, grant}), 128'(3'b101));
    wait_idle("t1_idle", 200);
    ev = '{64'h11, 64'h22, 64'h33};
    check_tx("t1_seq", ev);
    if (txlog.size() == 3 && srclog.size() == 3) begin
      check_int("t1_latency", txlog[0].cyc, srclog[0].cyc + 1);
      check_int("t1_consec1", txlog[1].cyc, txlog[0].cyc + 1);
      check_int("t1_consec2", txlog[2].cyc, txlog[1].cyc + 1);
      check_vec("t1_last_flags", 128'({txlog[0].last, txlog[1].last, txlog[2].last}), 128'(3'b001));
    end
    check_vec("t1_back_idle", 128'({grant, busy}), 128'(0));

    // simultaneous requests after reset, then round-robin
    do_reset();
    clear_logs();
    push_pkt(0, 64'hA0, 2);
    push_pkt(1, 64'hB0, 2);
    wait_idle("t2_idle", 200);
    ev = '{64'hA0, 64'hA1, 64'hB0, 64'hB1};
    check_tx("t2_tie_src0_first", ev);
    if (txlog.size() == 4) check_int("t2_no_bubble", txlog[2].cyc, txlog[1].cyc + 1);
    clear_logs();
    push_pkt(0, 64'hC0, 1);
    wait_idle("t2b_idle", 200);
    clear_logs();
    push_pkt(0, 64'hD0, 2);
    push_pkt(1, 64'hE0, 2);
    wait_idle("t2c_idle", 200);
    ev = '{64'hE0, 64'hE1, 64'hD0, 64'hD1};
    check_tx("t2_tie_src1_first", ev);
    if (txlog.size() == 4) check_int("t2c_no_bubble", txlog[2].cyc, txlog[1].cyc + 1);

    // owner stalls mid-packet while the other source waits
    clear_logs();
    push_beat(1, 64'h61, 8'hFF, 1'b0, 0);
    push_beat(1, 64'h62, 8'hFF, 1'b0, 5);
    push_beat(1, 64'h63, 8'h01, 1'b1, 0);
    wait_grant("t3_grant10", 2'b10);
    push_pkt(0, 64'h51, 2);
    repeat (5) begin
      @(negedge rx_clk);
      check_vec("t3_hold_grant", 128'({grant, src0_ready}), 128'(3'b100));
    end
    wait_idle("t3_idle", 200);
    ev = '{64'h61, 64'h62, 64'h63, 64'h51, 64'h52};
    check_tx("t3_seq", ev);

    // downstream stall during a 6-beat packet
    clear_logs();
    push_pkt(0, 64'h71, 6);
    wait_grant("t4_grant01", 2'b01);
    tr_mode = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge rx_clk);
      check_vec("t4_stall_data", 128'({tx_valid, tx_data}), 128'({1'b1, 64'h71}));
      if (i >= 2) check_vec("t4_ready_low", 128'(src0_ready), 128'(0));
    end
    tr_mode = 0;
    wait_idle("t4_idle", 200);
    ev = '{64'h71, 64'h72, 64'h73, 64'h74, 64'h75, 64'h76};
    check_tx("t4_seq", ev);

    // asynchronous reset in the middle of a packet
    clear_logs();
    push_pkt(0, 64'h81, 4);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge rx_clk);
      if (srclog.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout("t5_two_beats", 50);
    @(posedge rx_clk);
    #3;
    rx_reset = 1'b1;
    pq0.delete();
    #1;
    check_vec("t5_async_reset",
              128'({tx_valid, tx_last, tx_data, tx_keep, src0_ready, src1_ready, grant, busy}), 128'(0));
    repeat (2) @(negedge rx_clk);
    check_vec("t5_reset_hold", 128'({tx_valid, src0_ready, src1_ready, grant, busy}), 128'(0));
    @(posedge rx_clk);
    #3;
    rx_reset = 1'b0;
    @(negedge rx_clk);
    clear_logs();
    push_pkt(0, 64'h91, 4);
    wait_idle("t5_idle", 200);
    ev = '{64'h91, 64'h92, 64'h93, 64'h94};
    check_tx("t5_after_reset", ev);

    // randomized traffic
    clear_logs();
    rand_beats = 0;
    tr_mode = 2;
    for (int c = 0; c < 10000; c++) begin
      @(negedge rx_clk);
      if (pq0.size() < 3) push_rand_pkt(0);
      if (pq1.size() < 3) push_rand_pkt(1);
    end
    tr_mode = 0;
    wait_idle("rand_idle", 2000);
    check_int("rand_all_delivered", txlog.size(), rand_beats);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter data_width, default 64, AXI-Stream data width for sources and output.
REQ-002 Parameter keep_width, default 8, byte-enable width; SHALL equal data_width/8.
REQ-003 rx_clk  in  1  single bridge clock; all state on its rising edge.
REQ-004 rx_reset  in  1  asynchronous, active-high reset.
REQ-005 src0_data  in  data_width, src0_keep  in  keep_width, src0_valid  in  1, src0_last  in  1: completion-engine TLP stream.
REQ-006 src0_ready  out  1  beat accepted from source 0 when src0_valid && src0_ready.
REQ-007 src1_data  in  data_width, src1_keep  in  keep_width, src1_valid  in  1, src1_last  in  1: message/error-engine TLP stream.
REQ-008 src1_ready  out  1  beat accepted from source 1 when src1_valid && src1_ready.
REQ-009 tx_data  out  data_width, tx_keep  out  keep_width, tx_valid  out  1, tx_last  out  1: PCIe core AXI Tx stream.
REQ-010 tx_ready  in  1  PCIe core accepts a beat when tx_valid && tx_ready.
REQ-011 grant  out  2  one-hot current owner (01 = src0, 10 = src1, 00 = none).
REQ-012 busy  out  1  high while any packet is in flight or the output slice holds data.

Function
REQ-013 FSM states: IDLE, GRANT0, GRANT1; grant output SHALL be decoded from state.
REQ-014 IDLE: if exactly one srcN_valid high, next state GRANTN; if both high, grant the source not served last (last_grant pointer); else stay.
REQ-015 Arbitration takes one cycle: both srcN_ready SHALL be 0 in IDLE.
REQ-016 GRANTN: srcN_ready = output slice can accept; the non-granted source's ready SHALL be 0.
REQ-017 Grant is packet-locked: no switch until a beat with srcN_last = 1 is accepted from the owner.
REQ-018 Owner dropping srcN_valid mid-packet: hold grant indefinitely; no beats from the other source.
REQ-019 On acceptance of owner's last beat: if the other source's valid is high that cycle, go directly to its GRANT state (no IDLE bubble); else go to IDLE.
REQ-020 last_grant SHALL update to N on entering GRANTN.
REQ-021 Output path: 2-entry register slice (skid buffer); tx_* SHALL be driven from registers only, no combinational path from srcN_* or tx_ready to any tx_* output.
REQ-022 Latency: accepted source beat appears on tx_valid exactly 1 cycle later when the slice is empty.
REQ-023 Throughput: sustained 1 beat/cycle while owner valid and tx_ready are continuously high.
REQ-024 tx_data/tx_keep/tx_last SHALL be held stable while tx_valid && !tx_ready.
REQ-025 keep and last SHALL pass unmodified; beats SHALL be in order, never dropped or duplicated.
REQ-026 Slice full (2 entries) SHALL deassert granted srcN_ready the following cycle; no overflow.
REQ-027 busy = (state != IDLE) || slice not empty.

Reset
REQ-028 rx_reset assertion SHALL immediately force: state IDLE, last_grant = src1 (so src0 wins first tie), slice empty.
REQ-029 Output values during/after reset: tx_valid 0, tx_last 0, tx_data 0, tx_keep 0, src0_ready 0, src1_ready 0, grant 00, busy 0.
REQ-030 Reset mid-packet SHALL discard the in-flight packet and slice contents; no partial packet resumes after reset.

Structure
REQ-031 State encodings and data_width/keep_width defaults SHALL live in the shared bridge definitions include used by rx_fsm and the Rx/Tx engines.
REQ-032 The skid buffer SHALL be a separate sub-module axis_reg_slice (parameters data_width, keep_width) reusable by other bridge streams.
REQ-033 tx_arbiter SHALL contain only the FSM, last_grant pointer and ready/mux logic.

Verification
REQ-034 Reset then src0 sends 3-beat packet (data 0x11,0x22,0x33, last on beat 3), tx_ready=1 -> grant 01 after 1 cycle, tx beats 0x11,0x22,0x33 on consecutive cycles, tx_last on third, return to IDLE.
REQ-035 Both sources valid at once after reset, 2-beat packets each -> src0 packet first, then src1 with no idle cycle between tx_last and next tx_valid; repeat -> src1 first (round-robin).
REQ-036 src1 owns grant, drops valid for 5 cycles mid-packet while src0 valid -> src0_ready stays 0, grant stays 10, src1 packet completes intact.
REQ-037 tx_ready held 0 for 4 cycles during a 6-beat packet -> at most 2 beats buffered, srcN_ready falls, tx_data stable, all 6 beats delivered in order.
REQ-038 rx_reset asserted asynchronously at beat 2 of a 4-beat packet -> tx_valid, readies, grant, busy 0 without clock edge; next packet after release delivered complete.
REQ-039 Random valid/last/tx_ready for 10k cycles with scoreboard -> zero loss, reorder or interleaving of packets.
